// File: rtl/regfile_pkg.sv
// regfile_pkg: shared state enum and default geometry for the register file.
package regfile_pkg;
  typedef enum logic {CLEAR, RUN} state_e;
  localparam int XLEN = 32;
  localparam int NREGS = 32;
  localparam int REG_AW = 5;
  localparam int X0 = 0;
endpackage

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register pending bits with alloc-over-write priority and
// per-port busy lookup masked by a same-cycle write.
import regfile_pkg::*;
module reg_scoreboard #(
  parameter int DEPTH = NREGS,
  parameter int AW = REG_AW,
  parameter int NRD = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_run,
  input  logic            i_we,
  input  logic [AW-1:0]   i_wa,
  input  logic            i_alloc_en,
  input  logic [AW-1:0]   i_alloc_addr,
  input  logic [NRD*AW-1:0] i_ra,
  output logic [NRD-1:0]  o_busy
);
  logic [DEPTH-1:0] r_pend;
  logic [DEPTH-1:0] w_set;
  logic [DEPTH-1:0] w_clr;
  // Bit 0 can never be set, so x0 reads are never busy without an extra term.
  assign w_set = (i_run && i_alloc_en && i_alloc_addr != AW'(X0)) ? DEPTH'(1) << i_alloc_addr : '0;
  assign w_clr = (i_run && i_we && i_wa != AW'(X0)) ? DEPTH'(1) << i_wa : '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_pend <= '0;
    else r_pend <= (r_pend & ~w_clr) | w_set;
  for (genvar i = 0; i < NRD; i++) begin : g_port
    logic [AW-1:0] w_a;
    assign w_a = i_ra[i*AW +: AW];
    assign o_busy[i] = i_run && r_pend[w_a] && !(i_we && i_wa == w_a);
  end
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-read-port integer register file with sequential clear,
// write-to-read bypass, hardwired x0 and a pending scoreboard.
import regfile_pkg::*;
module regfile_mp #(
  parameter int W = XLEN,
  parameter int DEPTH = NREGS,
  parameter int AW = REG_AW,
  parameter int NRD = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              ready,
  input  logic              we,
  input  logic [AW-1:0]     wa,
  input  logic [W-1:0]      wd,
  input  logic              alloc_en,
  input  logic [AW-1:0]     alloc_addr,
  input  logic [NRD*AW-1:0] ra,
  output logic [NRD*W-1:0]  rd,
  output logic [NRD-1:0]    rbusy
);
  state_e        r_state;
  state_e        w_state_nxt;
  logic [AW-1:0] r_idx;
  logic          w_run;
  logic [W-1:0]  r_mem [DEPTH];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= CLEAR;
      r_idx <= AW'(1);
    end else begin
      r_state <= w_state_nxt;
      if (r_state == CLEAR) r_idx <= r_idx + AW'(1);
    end
  always_comb w_state_nxt = (r_state == CLEAR && r_idx == AW'(DEPTH-1)) ? RUN : r_state;
  always_comb begin
    w_run = (r_state == RUN);
    ready = w_run;
  end
  // Entry 0 is never stored; the read mux supplies its zero.
  always_ff @(posedge clk)
    if (!w_run) r_mem[r_idx] <= '0;
    else if (we && wa != AW'(X0)) r_mem[wa] <= wd;
  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0] w_a;
    assign w_a = ra[i*AW +: AW];
    assign rd[i*W +: W] = (!w_run || w_a == AW'(X0)) ? '0 : (we && wa == w_a) ? wd : r_mem[w_a];
  end
  reg_scoreboard #(.DEPTH(DEPTH), .AW(AW), .NRD(NRD)) u_sb (
    .clk(clk),
    .rst_n(rst_n),
    .i_run(w_run),
    .i_we(we),
    .i_wa(wa),
    .i_alloc_en(alloc_en),
    .i_alloc_addr(alloc_addr),
    .i_ra(ra),
    .o_busy(rbusy)
  );
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed and random checks of regfile_mp against a
// behavioural model of registers, pending bits and clear latency.
module tb_regfile_mp;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        ready;
  logic        we = 1'b0;
  logic [4:0]  wa = '0;
  logic [31:0] wd = '0;
  logic        alloc_en = 1'b0;
  logic [4:0]  alloc_addr = '0;
  logic [9:0]  ra = '0;
  logic [63:0] rd;
  logic [1:0]  rbusy;
  int total = 0;
  int bad = 0;
  bit checking = 1'b0;
  logic [31:0] mem_m [32];
  logic        pend_m [32];
  int          cnt = 0;

  regfile_mp dut (
    .clk(clk), .rst_n(rst_n), .ready(ready), .we(we), .wa(wa), .wd(wd),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr), .ra(ra), .rd(rd), .rbusy(rbusy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: clear takes 31 edges after reset, writes/allocs ignored until then.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 0;
      for (int k = 0; k < 32; k++) begin
        mem_m[k] <= '0;
        pend_m[k] <= 1'b0;
      end
    end else if (cnt < 31) cnt <= cnt + 1;
    else begin
      if (we && wa != 0) begin
        mem_m[wa] <= wd;
        pend_m[wa] <= 1'b0;
      end
      if (alloc_en && alloc_addr != 0) pend_m[alloc_addr] <= 1'b1;
    end
  end

  always @(negedge clk) begin
    #3;
    if (checking) begin
      logic run;
      run = (cnt >= 31);
      chk("m_ready", {31'b0, ready}, {31'b0, run});
      for (int p = 0; p < 2; p++) begin
        logic [4:0]  a;
        logic [31:0] e;
        logic        b;
        a = ra[p*5 +: 5];
        e = (!run || a == 0) ? 32'h0 : (we && wa == a) ? wd : mem_m[a];
        b = run && a != 0 && pend_m[a] && !(we && wa == a);
        chk("m_rd", rd[p*32 +: 32], e);
        chk("m_rbusy", {31'b0, rbusy[p]}, {31'b0, b});
      end
    end
  end

  task automatic drive(input logic w, input logic [4:0] a, input logic [31:0] d,
                       input logic al, input logic [4:0] aa, input logic [4:0] r0, input logic [4:0] r1);
    @(negedge clk);
    we = w; wa = a; wd = d; alloc_en = al; alloc_addr = aa; ra = {r1, r0};
    #2;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (n < 100) begin
      @(posedge clk);
      n++;
      #1;
      if (ready) break;
    end
  endtask

  initial begin
    int n;
    #1 rst_n = 1'b0;
    we = 1'b1; wa = 5'd3; wd = 32'hFFFF_FFFF; ra = {5'd3, 5'd3};
    #2;
    chk("rst_ready", {31'b0, ready}, 32'h0);
    chk("rst_rbusy", {30'b0, rbusy}, 32'h0);
    chk("rst_rd0", rd[31:0], 32'h0);
    checking = 1'b1;
    @(negedge clk);
    #1 rst_n = 1'b1;
    wait_ready(n);
    chk("clear_edges", n, 31);
    drive(0, 0, 0, 0, 0, 3, 3);
    chk("x3_after_clear", rd[31:0], 32'h0);
    drive(1, 5, 32'h1234_5678, 0, 0, 5, 5);
    chk("byp_rd0", rd[31:0], 32'h1234_5678);
    chk("byp_rd1", rd[63:32], 32'h1234_5678);
    drive(0, 0, 0, 0, 0, 5, 5);
    chk("arr_rd0", rd[31:0], 32'h1234_5678);
    chk("arr_rd1", rd[63:32], 32'h1234_5678);
    drive(1, 0, 32'hDEAD, 1, 0, 0, 0);
    chk("x0_rd", rd[31:0] | rd[63:32], 32'h0);
    chk("x0_busy", {30'b0, rbusy}, 32'h0);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("x0_busy_next", {30'b0, rbusy}, 32'h0);
    chk("x0_rd_next", rd[31:0], 32'h0);
    drive(0, 0, 0, 1, 7, 7, 7);
    chk("alloc_same_cyc", {30'b0, rbusy}, 32'h0);
    drive(0, 0, 0, 0, 0, 7, 7);
    chk("alloc_busy", {30'b0, rbusy}, 32'h3);
    drive(1, 7, 32'h55, 0, 0, 7, 7);
    chk("wr_unbusy", {30'b0, rbusy}, 32'h0);
    chk("wr_byp", rd[31:0], 32'h55);
    drive(0, 0, 0, 0, 0, 7, 7);
    chk("pend_clear", {30'b0, rbusy}, 32'h0);
    drive(1, 9, 32'h1, 1, 9, 9, 0);
    chk("coll_byp", rd[31:0], 32'h1);
    drive(0, 0, 0, 0, 0, 9, 9);
    chk("coll_rd", rd[31:0], 32'h1);
    chk("coll_busy", {30'b0, rbusy}, 32'h3);
    drive(1, 4, 32'd14, 0, 0, 4, 9);
    drive(0, 0, 0, 0, 0, 4, 9);
    chk("pre_rst_x4", rd[31:0], 32'd14);
    chk("pre_rst_busy", {30'b0, rbusy}, 32'h2);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", {31'b0, ready}, 32'h0);
    chk("mid_rst_busy", {30'b0, rbusy}, 32'h0);
    #1 rst_n = 1'b1;
    wait_ready(n);
    chk("reclear_edges", n, 31);
    drive(0, 0, 0, 0, 0, 4, 9);
    chk("x4_cleared", rd[31:0], 32'h0);
    chk("x9_unpend", {30'b0, rbusy}, 32'h0);
    for (int k = 0; k < 400; k++)
      drive(1'($urandom_range(1)), 5'($urandom_range(7)), $urandom, ($urandom_range(2) == 0),
            5'($urandom_range(7)), 5'($urandom_range(7)), 5'($urandom_range(7)));
    @(negedge clk);
    checking = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
